// File: rtl/sd_mod_cfg.sv
// Run-time selectable 1st/2nd order sigma-delta modulator: signed BW-bit PCM in,
// registered 1-bit bitstream out, with saturating integrators and a sticky overload flag.
module sd_mod_cfg #(
   parameter int BW    = 16,
   parameter int GUARD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [BW-1:0] sd_in,
   input  logic          sd_in_valid,
   input  logic          order_sel,
   input  logic          ovl_clr,
   output logic          bs_out,
   output logic          ovl
);

   localparam int IW = BW + GUARD;
   localparam int SW = IW + 2;

   localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(IW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(IW-1){1'b0}}};
   localparam logic signed [SW-1:0] FB_MAG  = {{(SW-BW){1'b0}}, 1'b1, {(BW-1){1'b0}}};

   typedef enum logic {ORD1 = 1'b0, ORD2 = 1'b1} order_t;

   logic signed [BW-1:0] x_reg;
   logic signed [IW-1:0] i1, i2;
   order_t               order_q;

   logic signed [IW-1:0] i1_nxt, i2_nxt;
   logic                 bs_nxt, ovl_nxt;
   order_t               order_nxt;

   logic signed [SW-1:0] fb, s1, s2;
   logic signed [IW-1:0] s1_sat, s2_sat;
   logic                 s1_clip, s2_clip, sat_hit;

   function automatic logic signed [IW-1:0] sat_fn(input logic signed [SW-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[IW-1:0];
      else if (v < SAT_MIN) return SAT_MIN[IW-1:0];
      else                  return v[IW-1:0];
   endfunction

   // Sums carry two extra bits so the worst-case integrator + input + feedback never wraps before clamping.
   always_comb begin
      fb      = bs_out ? FB_MAG : -FB_MAG;
      s1      = {{2{i1[IW-1]}}, i1} + {{(SW-BW){x_reg[BW-1]}}, x_reg} - fb;
      s1_sat  = sat_fn(s1);
      s1_clip = (s1 > SAT_MAX) || (s1 < SAT_MIN);
      s2      = {{2{i2[IW-1]}}, i2} + {{2{s1_sat[IW-1]}}, s1_sat} - fb;
      s2_sat  = sat_fn(s2);
      s2_clip = (s2 > SAT_MAX) || (s2 < SAT_MIN);
   end

   // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      i1_nxt    = i1;
      i2_nxt    = i2;
      bs_nxt    = bs_out;
      order_nxt = order_q;
      ovl_nxt   = ovl;
      sat_hit   = 1'b0;
      if (en) begin
         if (order_t'(order_sel) != order_q) begin
            // Order switch restarts the loop from a clean state; no integration this cycle.
            order_nxt = order_t'(order_sel);
            i1_nxt    = '0;
            i2_nxt    = '0;
            bs_nxt    = 1'b0;
         end else begin
            i1_nxt = s1_sat;
            if (order_q == ORD2) begin
               i2_nxt  = s2_sat;
               bs_nxt  = ~s2_sat[IW-1];
               sat_hit = s1_clip | s2_clip;
            end else begin
               i2_nxt  = '0;
               bs_nxt  = ~s1_sat[IW-1];
               sat_hit = s1_clip;
            end
         end
         // Set is evaluated last so a coincident saturation beats the clear.
         if (ovl_clr) ovl_nxt = 1'b0;
         if (sat_hit) ovl_nxt = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg   <= '0;
         i1      <= '0;
         i2      <= '0;
         bs_out  <= 1'b0;
         ovl     <= 1'b0;
         order_q <= ORD1;
      end else begin
         if (sd_in_valid) x_reg <= sd_in;
         i1      <= i1_nxt;
         i2      <= i2_nxt;
         bs_out  <= bs_nxt;
         ovl     <= ovl_nxt;
         order_q <= order_nxt;
      end
   end

endmodule
